// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch counting stage.
//   - sw_state_e : control FSM encoding (STOP / RUN / CLEAR)
//   - TICK_DIV   : default system clocks per centisecond tick (100 MHz -> 100 Hz)
//   - *_MAX      : default moduli of the hundredths/seconds/minutes/hours chain
// -----------------------------------------------------------------------------
package stopwatch_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      RUN   = 2'd1,
      CLEAR = 2'd2
   } sw_state_e;

   localparam int TICK_DIV = 1_000_000;
   localparam int MSEC_MAX = 100;
   localparam int SEC_MAX  = 60;
   localparam int MIN_MAX  = 60;
   localparam int HOUR_MAX = 24;

endpackage : stopwatch_pkg

// File: rtl/stopwatch_counter_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Parameterised clock divider with enable and synchronous clear. The count
// advances only while i_en is high and holds otherwise, so a paused divider
// keeps its partial count. o_tick is high for the single enabled cycle in
// which the count sits at DIV-1; the count wraps to 0 on that edge.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high reset (count -> 0)
//   i_en    in   count enable
//   i_clr   in   synchronous clear (count -> 0), higher priority than i_en
//   o_tick  out  one-cycle terminal-count strobe (combinational)
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int DIV = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   // A divide-by-1 still needs a one-bit register to stay legal.
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   assign o_tick = i_en && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         cnt_q <= '0;
      end else if (i_en) begin
         if (o_tick) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule : tick_gen

// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
// Time base and counting stage of the stopwatch. A tick_gen divides clk down
// to a centisecond tick; the tick drives a hundredths -> seconds -> minutes ->
// hours cascade. A small FSM (STOP / RUN / CLEAR) driven by debounced button
// pulses gates the divider and handles clearing.
//
// Button inputs are single-cycle pulses: a pulse is acted on in the cycle it
// is high and there is no acknowledge or back-pressure.
//
// Ports:
//   clk          in   system clock (100 MHz)
//   reset        in   synchronous, active-high reset; dominates all inputs
//   i_btn_run    in   one-cycle pulse, toggles STOP <-> RUN
//   i_btn_clear  in   one-cycle pulse, clears counters (STOP only)
//   o_msec       out  hundredths 0..MSEC_MAX-1
//   o_sec        out  seconds    0..SEC_MAX-1
//   o_min        out  minutes    0..MIN_MAX-1
//   o_hour       out  hours      0..HOUR_MAX-1
//   o_running    out  registered, high exactly while the state is RUN
//   o_state      out  current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module stopwatch_counter
   import stopwatch_pkg::sw_state_e;
   import stopwatch_pkg::STOP;
   import stopwatch_pkg::RUN;
   import stopwatch_pkg::CLEAR;
#(
   parameter int TICK_DIV = stopwatch_pkg::TICK_DIV,
   parameter int MSEC_MAX = stopwatch_pkg::MSEC_MAX,
   parameter int SEC_MAX  = stopwatch_pkg::SEC_MAX,
   parameter int MIN_MAX  = stopwatch_pkg::MIN_MAX,
   parameter int HOUR_MAX = stopwatch_pkg::HOUR_MAX
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_btn_run,
   input  logic       i_btn_clear,
   output logic [6:0] o_msec,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hour,
   output logic       o_running,
   output logic [1:0] o_state
);

   // Terminal values of each stage, sized to the counter they are compared with.
   localparam logic [6:0] MSEC_LAST = 7'(MSEC_MAX - 1);
   localparam logic [5:0] SEC_LAST  = 6'(SEC_MAX - 1);
   localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX - 1);
   localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX - 1);

   sw_state_e state_q;
   sw_state_e state_d;

   logic       running_q;
   logic       tick;
   logic       div_en;
   logic       div_clr;

   logic [6:0] msec_q;
   logic [5:0] sec_q;
   logic [5:0] min_q;
   logic [4:0] hour_q;

   logic       msec_wrap;
   logic       sec_wrap;
   logic       min_wrap;
   logic       hour_wrap;

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= STOP;
      end else begin
         state_q <= state_d;
      end
   end

   // Clear has priority over run in STOP, so a simultaneous run pulse is lost.
   always_comb begin
      state_d = state_q;
      case (state_q)
         STOP: begin
            if (i_btn_clear) begin
               state_d = CLEAR;
            end else if (i_btn_run) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (i_btn_run) begin
               state_d = STOP;
            end
         end
         CLEAR: begin
            state_d = STOP;
         end
         default: begin
            state_d = STOP;
         end
      endcase
   end

   // Loaded from the next state so the flop tracks state_q cycle for cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         running_q <= 1'b0;
      end else begin
         running_q <= (state_d == RUN);
      end
   end

   assign o_running = running_q;
   assign o_state   = state_q;

   // ---------------------------------------------------------------------------
   // Centisecond time base
   // ---------------------------------------------------------------------------
   // The divider only advances in RUN; in STOP it holds so that a pause/resume
   // does not lose the partial tick. A tick in the cycle of a stop pulse is
   // still counted because that cycle belongs to RUN.
   assign div_en  = (state_q == RUN);
   assign div_clr = (state_q == CLEAR);

   tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .i_en   (div_en),
      .i_clr  (div_clr),
      .o_tick (tick)
   );

   // ---------------------------------------------------------------------------
   // Counter cascade
   // ---------------------------------------------------------------------------
   assign msec_wrap = (msec_q == MSEC_LAST);
   assign sec_wrap  = (sec_q  == SEC_LAST);
   assign min_wrap  = (min_q  == MIN_LAST);
   assign hour_wrap = (hour_q == HOUR_LAST);

   // Carries ripple combinationally within one tick, so a full rollover to
   // 00:00:00.00 completes on a single edge. Hour overflow is silent.
   always_ff @(posedge clk) begin
      if (reset || (state_q == CLEAR)) begin
         msec_q <= '0;
         sec_q  <= '0;
         min_q  <= '0;
         hour_q <= '0;
      end else if (tick) begin
         if (msec_wrap) begin
            msec_q <= '0;
            if (sec_wrap) begin
               sec_q <= '0;
               if (min_wrap) begin
                  min_q <= '0;
                  if (hour_wrap) begin
                     hour_q <= '0;
                  end else begin
                     hour_q <= hour_q + 1'b1;
                  end
               end else begin
                  min_q <= min_q + 1'b1;
               end
            end else begin
               sec_q <= sec_q + 1'b1;
            end
         end else begin
            msec_q <= msec_q + 1'b1;
         end
      end
   end

   assign o_msec = msec_q;
   assign o_sec  = sec_q;
   assign o_min  = min_q;
   assign o_hour = hour_q;

endmodule : stopwatch_counter

// File: tb/tb_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_counter
// Directed bench for stopwatch_counter. u_dut runs with TICK_DIV=4 and the
// real moduli; u_small uses tiny moduli (5/3/3/2, TICK_DIV=2) so the full
// hours rollover can be reached in a few hundred cycles.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_stopwatch_counter;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk;
   logic reset;
   logic s_reset;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // DUT signals
   // ---------------------------------------------------------------------------
   logic       i_btn_run, i_btn_clear;
   logic [6:0] o_msec;
   logic [5:0] o_sec, o_min;
   logic [4:0] o_hour;
   logic       o_running;
   logic [1:0] o_state;

   logic       s_run, s_clear;
   logic [6:0] s_msec;
   logic [5:0] s_sec, s_min;
   logic [4:0] s_hour;
   logic       s_running;
   logic [1:0] s_state;

   stopwatch_counter #(
      .TICK_DIV (4)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .i_btn_run   (i_btn_run),
      .i_btn_clear (i_btn_clear),
      .o_msec      (o_msec),
      .o_sec       (o_sec),
      .o_min       (o_min),
      .o_hour      (o_hour),
      .o_running   (o_running),
      .o_state     (o_state)
   );

   stopwatch_counter #(
      .TICK_DIV (2),
      .MSEC_MAX (5),
      .SEC_MAX  (3),
      .MIN_MAX  (3),
      .HOUR_MAX (2)
   ) u_small (
      .clk         (clk),
      .reset       (s_reset),
      .i_btn_run   (s_run),
      .i_btn_clear (s_clear),
      .o_msec      (s_msec),
      .o_sec       (s_sec),
      .o_min       (s_min),
      .o_hour      (s_hour),
      .o_running   (s_running),
      .o_state     (s_state)
   );

   localparam logic [1:0] ST_STOP  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [6:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_main(input string tag, input int h, input int m, input int s,
                             input int ms);
      check({tag, "_hour"}, 32'(o_hour), 32'(h));
      check({tag, "_min"},  32'(o_min),  32'(m));
      check({tag, "_sec"},  32'(o_sec),  32'(s));
      check({tag, "_msec"}, 32'(o_msec), 32'(ms));
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_run();
      i_btn_run = 1'b1;
      cycles(1);
      i_btn_run = 1'b0;
   endtask

   task automatic pulse_clear();
      i_btn_clear = 1'b1;
      cycles(1);
      i_btn_clear = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      reset       = 1'b1;
      s_reset     = 1'b1;
      i_btn_run   = 1'b0;
      i_btn_clear = 1'b0;
      s_run       = 1'b0;
      s_clear     = 1'b0;
      cycles(3);
      reset   = 1'b0;
      s_reset = 1'b0;

      // Reset state and idle hold
      check_main("rst", 0, 0, 0, 0);
      check("rst_running", 32'(o_running), 0);
      check("rst_state", 32'(o_state), 32'(ST_STOP));
      check("rst_small_msec", 32'(s_msec), 0);
      check("rst_small_running", 32'(s_running), 0);
      cycles(100);
      check_main("idle", 0, 0, 0, 0);
      check("idle_running", 32'(o_running), 0);

      // Run: one hundredth every 4 cycles, visible the edge after the tick
      pulse_run();
      check("run_running", 32'(o_running), 1);
      check("run_state", 32'(o_state), 32'(ST_RUN));
      for (int k = 1; k <= 8; k++) begin
         exp_q.push_back(7'(k - 1));
         cycles(3);
         check("step_before", 32'(o_msec), 32'(exp_q.pop_front()));
         exp_q.push_back(7'(k));
         cycles(1);
         check("step_after", 32'(o_msec), 32'(exp_q.pop_front()));
      end
      cycles(600 - 32);
      check_main("run600", 0, 0, 1, 50);
      check("run600_running", 32'(o_running), 1);

      // Pause with divider at 2, resume: two more RUN cycles complete the tick
      cycles(5);
      check("pre_pause_msec", 32'(o_msec), 51);
      pulse_run();
      check("pause_running", 32'(o_running), 0);
      cycles(50);
      check("paused_msec", 32'(o_msec), 51);
      check("paused_running", 32'(o_running), 0);
      pulse_run();
      check("resume_running", 32'(o_running), 1);
      check("resume_msec", 32'(o_msec), 51);
      cycles(1);
      check("resume_1_msec", 32'(o_msec), 51);
      cycles(1);
      check("resume_2_msec", 32'(o_msec), 52);

      // Clear in RUN is ignored
      pulse_clear();
      check("clr_run_state", 32'(o_state), 32'(ST_RUN));
      check("clr_run_msec", 32'(o_msec), 52);
      cycles(3);
      check_main("clr_run_cont", 0, 0, 1, 53);

      // Clear in STOP
      pulse_run();
      check("stop_running", 32'(o_running), 0);
      pulse_clear();
      check("clr_state", 32'(o_state), 32'(ST_CLEAR));
      check("clr_hold_msec", 32'(o_msec), 53);
      cycles(1);
      check_main("cleared", 0, 0, 0, 0);
      check("cleared_state", 32'(o_state), 32'(ST_STOP));
      check("cleared_running", 32'(o_running), 0);

      // Stop pulse coincident with a tick: tick is counted
      pulse_run();
      cycles(7);
      check("pre_stop_tick_msec", 32'(o_msec), 1);
      pulse_run();
      check("stop_tick_msec", 32'(o_msec), 2);
      check("stop_tick_state", 32'(o_state), 32'(ST_STOP));
      check("stop_tick_running", 32'(o_running), 0);

      // Run and clear together in STOP: clear wins
      i_btn_run   = 1'b1;
      i_btn_clear = 1'b1;
      cycles(1);
      i_btn_run   = 1'b0;
      i_btn_clear = 1'b0;
      check("both_state", 32'(o_state), 32'(ST_CLEAR));
      check("both_running", 32'(o_running), 0);
      cycles(1);
      check("both_msec", 32'(o_msec), 0);
      check("both_state2", 32'(o_state), 32'(ST_STOP));
      cycles(10);
      check("both_running_late", 32'(o_running), 0);
      check("both_msec_late", 32'(o_msec), 0);

      // Reset mid-RUN coincident with a tick: tick not applied
      pulse_run();
      cycles(7);
      check("pre_reset_msec", 32'(o_msec), 1);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      check_main("mid_reset", 0, 0, 0, 0);
      check("mid_reset_running", 32'(o_running), 0);
      check("mid_reset_state", 32'(o_state), 32'(ST_STOP));
      // Divider was zeroed: first tick needs a full 4 RUN cycles
      pulse_run();
      cycles(3);
      check("post_reset_div3", 32'(o_msec), 0);
      cycles(1);
      check("post_reset_div4", 32'(o_msec), 1);

      // Full rollover on the small-moduli instance (88 ticks = 1:2:2.3)
      s_run = 1'b1;
      cycles(1);
      s_run = 1'b0;
      cycles(176);
      check("small_hour", 32'(s_hour), 1);
      check("small_min",  32'(s_min),  2);
      check("small_sec",  32'(s_sec),  2);
      check("small_msec", 32'(s_msec), 3);
      cycles(2);
      check("small_last_msec", 32'(s_msec), 4);
      check("small_last_hour", 32'(s_hour), 1);
      cycles(1);
      check("small_hold_msec", 32'(s_msec), 4);
      cycles(1);
      check("roll_hour", 32'(s_hour), 0);
      check("roll_min",  32'(s_min),  0);
      check("roll_sec",  32'(s_sec),  0);
      check("roll_msec", 32'(s_msec), 0);
      check("roll_running", 32'(s_running), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_stopwatch_counter
